pwm_multi: RTL and testbench

- Multi-channel, parametrised PWM generator. It is the next generation of the single-channel 8-bit sample PWM in the audio output path.
- N_CH channels share one period counter. Each channel has its own WIDTH-bit duty value.
- Period length and alignment mode (edge or centre) are programmable at run time.
- Period, mode and duty values are double-buffered and take effect only at a period boundary, so a period is never cut short or glitched.
- Outputs feed the pad drivers / output mixer stage directly.

---
 rtl/pwm_multi_if.sv | 25 ++
 rtl/pwm_multi.sv | 116 +++++++++++
 tb/tb_pwm_multi.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/pwm_multi_if.sv
// Control/status bundle for pwm_multi: staged configuration in, PWM outputs and status out.
// The master drives configuration; the slave (the PWM block) drives the outputs.
interface pwm_multi_if #(
   parameter int WIDTH = 8,
   parameter int N_CH  = 4
);
   logic                    enable;
   logic                    mode;
   logic [WIDTH-1:0]        period;
   logic [N_CH*WIDTH-1:0]   duty;
   logic                    load;
   logic [N_CH-1:0]         pwm_o;
   logic                    period_done;
   logic                    load_pending;

   modport master (
      output enable, mode, period, duty, load,
      input  pwm_o, period_done, load_pending
   );

   modport slave (
      input  enable, mode, period, duty, load,
      output pwm_o, period_done, load_pending
   );
endinterface

// File: rtl/pwm_multi.sv
// Multi-channel PWM generator sharing one period counter, with edge or centre alignment.
// Period, mode and duty are double-buffered and only switch over at a period boundary.
module pwm_multi #(
   parameter int WIDTH = 8,
   parameter int N_CH  = 4
) (
   input  logic       clk,
   input  logic       rst,
   pwm_multi_if.slave bus
);
   typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0]      cnt;
   logic [WIDTH-1:0]      cnt_next;
   dir_t                  dir;
   dir_t                  dir_next;

   logic [WIDTH-1:0]      act_top;
   logic                  act_mode;
   logic [N_CH*WIDTH-1:0] act_duty;
   logic [WIDTH-1:0]      stg_top;
   logic                  stg_mode;
   logic [N_CH*WIDTH-1:0] stg_duty;
   logic                  load_pending;

   logic                  centre;
   logic                  boundary;
   logic                  transfer;
   logic [N_CH-1:0]       raw;
   logic [N_CH-1:0]       pwm_q;
   logic                  period_done_q;

   // Centre mode needs TOP>=2 to have a distinct up and down leg; otherwise fall back to edge.
   always_comb begin
      centre   = act_mode && (act_top > ONE);
      boundary = !bus.enable || (centre ? ((dir == DIR_DOWN) && (cnt == ONE))
                                        : (cnt == act_top));
      transfer = boundary && (bus.load || load_pending);
   end

   always_comb begin
      cnt_next = cnt;
      dir_next = dir;
      if (!bus.enable || transfer) begin
         cnt_next = '0;
         dir_next = DIR_UP;
      end else if (!centre) begin
         cnt_next = (cnt == act_top) ? '0 : cnt + ONE;
         dir_next = DIR_UP;
      end else if (dir == DIR_UP) begin
         cnt_next = cnt + ONE;
         if (cnt == act_top - ONE) dir_next = DIR_DOWN;
      end else begin
         cnt_next = cnt - ONE;
         if (cnt == ONE) dir_next = DIR_UP;
      end
   end

   // The down leg uses <= so the high time is symmetric around cnt=0.
   always_comb begin
      raw = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (centre && (dir == DIR_DOWN))
            raw[i] = (cnt <= act_duty[i*WIDTH +: WIDTH]);
         else
            raw[i] = (cnt < act_duty[i*WIDTH +: WIDTH]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt           <= '0;
         dir           <= DIR_UP;
         pwm_q         <= '0;
         period_done_q <= 1'b0;
      end else begin
         cnt           <= cnt_next;
         dir           <= dir_next;
         pwm_q         <= bus.enable ? raw : '0;
         period_done_q <= bus.enable && boundary;
      end
   end

   // A load in the boundary cycle bypasses staging so load_pending never rises for it.
   always_ff @(posedge clk) begin
      if (rst) begin
         act_top      <= '1;
         act_mode     <= 1'b0;
         act_duty     <= '0;
         stg_top      <= '1;
         stg_mode     <= 1'b0;
         stg_duty     <= '0;
         load_pending <= 1'b0;
      end else begin
         if (bus.load) begin
            stg_top  <= bus.period;
            stg_mode <= bus.mode;
            stg_duty <= bus.duty;
         end
         if (transfer) begin
            act_top      <= bus.load ? bus.period : stg_top;
            act_mode     <= bus.load ? bus.mode   : stg_mode;
            act_duty     <= bus.load ? bus.duty   : stg_duty;
            load_pending <= 1'b0;
         end else if (bus.load) begin
            load_pending <= 1'b1;
         end
      end
   end

   assign bus.pwm_o        = pwm_q;
   assign bus.period_done  = period_done_q;
   assign bus.load_pending = load_pending;
endmodule

// File: tb/tb_pwm_multi.sv
// Scoreboard bench for pwm_multi: expected per-period window stats are queued by the stimulus
// and popped by a monitor at each period_done; plus direct status checks around loads/reset.
module tb_pwm_multi;
   logic clk;
   logic rst;

   pwm_multi_if #(.WIDTH(8), .N_CH(4)) bus ();

   pwm_multi #(.WIDTH(8), .N_CH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct packed {
      logic [15:0]      len;
      logic [3:0][15:0] high;
   } window_t;

   window_t exp_q[$];
   window_t exp_w;
   int      checks_total;
   int      checks_passed;
   int      win_len;
   int      win_high[4];
   bit      win_active;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string name, input int actual, input int expected);
      checks_total++;
      if (actual == expected) checks_passed++;
      else $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
   endtask

   function automatic window_t make_window(input int len, input int h0, input int h1,
                                           input int h2, input int h3);
      window_t w;
      w.len     = 16'(len);
      w.high[0] = 16'(h0);
      w.high[1] = 16'(h1);
      w.high[2] = 16'(h2);
      w.high[3] = 16'(h3);
      return w;
   endfunction

   // A window runs from one period_done cycle up to the next; its stats are compared on close.
   always @(negedge clk) begin
      if (rst) begin
         win_active = 1'b0;
      end else begin
         if (bus.period_done) begin
            if (win_active && (exp_q.size() > 0)) begin
               exp_w = exp_q.pop_front();
               check_output("win_len", win_len, int'(exp_w.len));
               for (int i = 0; i < 4; i++)
                  check_output($sformatf("win_high_ch%0d", i), win_high[i], int'(exp_w.high[i]));
            end
            win_len = 0;
            for (int i = 0; i < 4; i++) win_high[i] = 0;
            win_active = 1'b1;
         end
         win_len++;
         for (int i = 0; i < 4; i++) if (bus.pwm_o[i]) win_high[i]++;
      end
   end

   task automatic apply_stimulus(input logic m, input logic [7:0] p, input logic [31:0] d);
      bus.mode   = m;
      bus.period = p;
      bus.duty   = d;
      bus.load   = 1'b1;
      @(negedge clk);
      bus.load   = 1'b0;
   endtask

   task automatic wait_pd();
      int n;
      n = 0;
      @(negedge clk);
      while (!bus.period_done && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (!bus.period_done) check_output("wait_pd_timeout", n, 0);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         check_output("drain_timeout", exp_q.size(), 0);
         exp_q.delete();
      end
   endtask

   // Load a config while running, skip the transition window, then score n windows.
   task automatic run_config(input logic m, input logic [7:0] p, input logic [31:0] d,
                             input int n, input window_t w);
      apply_stimulus(m, p, d);
      wait_pd();
      wait_pd();
      @(posedge clk);
      for (int i = 0; i < n; i++) exp_q.push_back(w);
      drain();
   endtask

   initial begin
      int k;
      checks_total  = 0;
      checks_passed = 0;
      rst        = 1'b1;
      bus.enable = 1'b0;
      bus.mode   = 1'b0;
      bus.period = 8'd0;
      bus.duty   = 32'd0;
      bus.load   = 1'b0;
      repeat (3) @(negedge clk);
      check_output("rst_pwm_o", int'(bus.pwm_o), 0);
      check_output("rst_period_done", int'(bus.period_done), 0);
      check_output("rst_load_pending", int'(bus.load_pending), 0);
      rst = 1'b0;

      // Disabled cycles are boundaries, so this load lands directly.
      apply_stimulus(1'b0, 8'd255, {8'd0, 8'd0, 8'd0, 8'd64});
      check_output("disabled_load_pending", int'(bus.load_pending), 0);
      bus.enable = 1'b1;
      wait_pd();
      @(posedge clk);
      exp_q.push_back(make_window(256, 64, 0, 0, 0));
      exp_q.push_back(make_window(256, 64, 0, 0, 0));
      drain();

      run_config(1'b0, 8'd9, {8'd200, 8'd10, 8'd5, 8'd0}, 2, make_window(10, 0, 5, 10, 10));
      run_config(1'b1, 8'd4, {8'd0, 8'd1, 8'd9, 8'd2}, 2, make_window(8, 4, 8, 2, 0));
      run_config(1'b1, 8'd1, {8'd0, 8'd1, 8'd9, 8'd2}, 3, make_window(2, 2, 2, 1, 0));

      // Mid-period load at cnt=3: current period keeps old duty, next one uses the new duty.
      apply_stimulus(1'b0, 8'd9, {8'd0, 8'd0, 8'd0, 8'd5});
      wait_pd();
      wait_pd();
      repeat (3) @(negedge clk);
      exp_q.push_back(make_window(10, 5, 0, 0, 0));
      exp_q.push_back(make_window(10, 8, 0, 0, 0));
      apply_stimulus(1'b0, 8'd9, {8'd0, 8'd0, 8'd0, 8'd8});
      check_output("mid_load_pending_set", int'(bus.load_pending), 1);
      repeat (5) @(negedge clk);
      check_output("mid_load_pending_held", int'(bus.load_pending), 1);
      @(negedge clk);
      check_output("mid_load_pending_clear", int'(bus.load_pending), 0);
      check_output("mid_period_done", int'(bus.period_done), 1);
      drain();

      // Load exactly in the cnt==TOP cycle.
      wait_pd();
      repeat (9) @(negedge clk);
      apply_stimulus(1'b0, 8'd9, {8'd0, 8'd0, 8'd0, 8'd3});
      check_output("bnd_load_pending", int'(bus.load_pending), 0);
      check_output("bnd_period_done", int'(bus.period_done), 1);
      @(posedge clk);
      exp_q.push_back(make_window(10, 3, 0, 0, 0));
      @(negedge clk);
      check_output("bnd_load_pending_after", int'(bus.load_pending), 0);
      drain();

      // Drop enable at cnt=6, re-enable, and time the restart to the next period_done.
      wait_pd();
      repeat (6) @(negedge clk);
      bus.enable = 1'b0;
      @(negedge clk);
      check_output("dis_pwm_o", int'(bus.pwm_o), 0);
      check_output("dis_period_done", int'(bus.period_done), 0);
      bus.enable = 1'b1;
      @(negedge clk);
      check_output("reen_pwm_o0", int'(bus.pwm_o[0]), 1);
      k = 1;
      while (!bus.period_done && k < 100) begin
         @(negedge clk);
         k++;
      end
      check_output("reen_restart_len", k, 10);

      // Reset with staged data pending: staged values are lost, defaults take over.
      wait_pd();
      repeat (3) @(negedge clk);
      apply_stimulus(1'b0, 8'd9, {8'd0, 8'd0, 8'd0, 8'd7});
      check_output("pre_rst_load_pending", int'(bus.load_pending), 1);
      rst = 1'b1;
      @(negedge clk);
      check_output("mid_rst_pwm_o", int'(bus.pwm_o), 0);
      check_output("mid_rst_load_pending", int'(bus.load_pending), 0);
      check_output("mid_rst_period_done", int'(bus.period_done), 0);
      rst = 1'b0;
      wait_pd();
      @(posedge clk);
      exp_q.push_back(make_window(256, 0, 0, 0, 0));
      drain();

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end
endmodule
